// File: rtl/dat_mem_stack.sv
// rtl/dat_mem_stack.sv - data memory with load/store port, downward stack and writeback mux
// The stack shares the array: slot n (n = 0 at the bottom) lives at STACK_BASE - n.
module dat_mem_stack #(
  parameter int DW          = 8,
  parameter int AW          = 8,
  parameter int STACK_DEPTH = 16,
  parameter int STACK_BASE  = 2**AW - 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               wr_en,
  input  logic                               rd_en,
  input  logic                               push,
  input  logic                               pop,
  input  logic [AW-1:0]                      addr,
  input  logic [DW-1:0]                      dat_in,
  input  logic [DW-1:0]                      ALU_out,
  input  logic                               memToReg,
  output logic [DW-1:0]                      dat_out,
  output logic                               rd_valid,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
  output logic                               full,
  output logic                               empty,
  output logic                               err
);

  localparam int SPW = $clog2(STACK_DEPTH + 1);

  // Keeps STACK_BASE - sp inside the array for every reachable sp.
  if (STACK_DEPTH < 1 || STACK_DEPTH > STACK_BASE + 1 || STACK_BASE > 2**AW - 1) begin : g_bad_params
    $error("dat_mem_stack: STACK_DEPTH/STACK_BASE out of range");
  end

  logic [DW-1:0]  core [2**AW];
  logic [DW-1:0]  rd_data;
  logic [SPW-1:0] sp_q;
  logic [2:0]     op_cnt;
  logic           multi;
  logic           do_store, do_load, do_push, do_pop;
  logic           mem_we;
  logic [AW-1:0]  push_addr, pop_addr, mem_waddr, mem_raddr;
  logic           err_next;

  assign op_cnt = 3'(wr_en) + 3'(rd_en) + 3'(push) + 3'(pop);
  assign multi  = op_cnt > 3'd1;

  assign full  = sp_q == SPW'(STACK_DEPTH);
  assign empty = sp_q == '0;

  assign push_addr = AW'(STACK_BASE - int'(sp_q));
  assign pop_addr  = AW'(STACK_BASE - int'(sp_q) + 1);

  assign do_store = wr_en & ~multi;
  assign do_load  = rd_en & ~multi;
  assign do_push  = push  & ~multi & ~full;
  assign do_pop   = pop   & ~multi & ~empty;

  assign mem_we    = do_store | do_push;
  assign mem_waddr = do_store ? addr : push_addr;
  assign mem_raddr = do_pop ? pop_addr : addr;

  assign err_next = multi | (push & full) | (pop & empty);

  // Contents survive reset; reset only suppresses a write landing in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (!reset && mem_we) begin
      core[mem_waddr] <= dat_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q     <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      rd_valid <= do_load | do_pop;
      err      <= err_next;
      if (do_load || do_pop) begin
        rd_data <= core[mem_raddr];
      end
      if (do_push) begin
        sp_q <= sp_q + SPW'(1);
      end else if (do_pop) begin
        sp_q <= sp_q - SPW'(1);
      end
    end
  end

  assign sp      = sp_q;
  assign dat_out = memToReg ? rd_data : ALU_out;

endmodule

// File: tb/tb_dat_mem_stack.sv
// tb/tb_dat_mem_stack.sv - bench for dat_mem_stack: vector table, corner sequences, random vs model
module tb_dat_mem_stack;

  localparam int DEPTH = 16;
  localparam int BASE  = 255;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0, rd_en = 1'b0, push = 1'b0, pop = 1'b0;
  logic [7:0] addr = '0, dat_in = '0, ALU_out = '0;
  logic       memToReg = 1'b0;
  logic [7:0] dat_out;
  logic       rd_valid, full, empty, err;
  logic [4:0] sp;

  int n_chk = 0;
  int n_fail = 0;

  dat_mem_stack #(.DW(8), .AW(8), .STACK_DEPTH(DEPTH), .STACK_BASE(BASE)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .push(push), .pop(pop),
    .addr(addr), .dat_in(dat_in), .ALU_out(ALU_out), .memToReg(memToReg),
    .dat_out(dat_out), .rd_valid(rd_valid), .sp(sp), .full(full), .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      nm;
    logic [3:0] op;   // {wr, rd, push, pop}
    logic [7:0] a, d;
    logic       mtr;
    logic [7:0] alu;
    logic       ev, ee;
    int         esp;
    logic [7:0] edo;
  } vec_t;

  localparam logic [3:0] IDLE = 4'b0000, ST = 4'b1000, LD = 4'b0100, PU = 4'b0010, PO = 4'b0001;

  function automatic vec_t mk(string nm, logic [3:0] op, logic [7:0] a, logic [7:0] d,
                              logic mtr, logic [7:0] alu, logic ev, logic ee, int esp, logic [7:0] edo);
    vec_t v;
    v.nm = nm; v.op = op; v.a = a; v.d = d; v.mtr = mtr; v.alu = alu;
    v.ev = ev; v.ee = ee; v.esp = esp; v.edo = edo;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then land 1 time unit after the edge that consumed them.
  task automatic apply(input logic [3:0] op, input logic [7:0] a, input logic [7:0] d,
                       input logic mtr, input logic [7:0] alu);
    {wr_en, rd_en, push, pop} = op;
    addr = a; dat_in = d; memToReg = mtr; ALU_out = alu;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string nm, input logic ev, input logic ee, input int esp, input logic [7:0] edo);
    chk({nm, ".rd_valid"}, 32'(rd_valid), 32'(ev));
    chk({nm, ".err"},      32'(err),      32'(ee));
    chk({nm, ".sp"},       32'(sp),       32'(esp));
    chk({nm, ".full"},     32'(full),     32'(esp == DEPTH));
    chk({nm, ".empty"},    32'(empty),    32'(esp == 0));
    chk({nm, ".dat_out"},  32'(dat_out),  32'(edo));
  endtask

  task automatic do_reset();
    {wr_en, rd_en, push, pop} = IDLE;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  vec_t tbl[$];
  logic [7:0] mmem [256];
  int         msp;
  logic [7:0] mrd;

  initial begin
    tbl.push_back(mk("idle_mtr1",  IDLE, 8'h00, 8'h00, 1, 8'h00, 0, 0, 0, 8'h00));
    tbl.push_back(mk("idle_alu",   IDLE, 8'h00, 8'h00, 0, 8'h5A, 0, 0, 0, 8'h5A));
    tbl.push_back(mk("store_3c",   ST,   8'h10, 8'h3C, 0, 8'h77, 0, 0, 0, 8'h77));
    tbl.push_back(mk("load_10",    LD,   8'h10, 8'h00, 1, 8'h00, 1, 0, 0, 8'h3C));
    tbl.push_back(mk("after_load", IDLE, 8'h00, 8'h00, 1, 8'h00, 0, 0, 0, 8'h3C));
    tbl.push_back(mk("push_11",    PU,   8'h00, 8'h11, 0, 8'h00, 0, 0, 1, 8'h00));
    tbl.push_back(mk("push_22",    PU,   8'h00, 8'h22, 0, 8'h00, 0, 0, 2, 8'h00));
    tbl.push_back(mk("push_33",    PU,   8'h00, 8'h33, 0, 8'h00, 0, 0, 3, 8'h00));
    tbl.push_back(mk("pop_33",     PO,   8'h00, 8'h00, 1, 8'h00, 1, 0, 2, 8'h33));
    tbl.push_back(mk("pop_22",     PO,   8'h00, 8'h00, 1, 8'h00, 1, 0, 1, 8'h22));
    tbl.push_back(mk("pop_11",     PO,   8'h00, 8'h00, 1, 8'h00, 1, 0, 0, 8'h11));
    tbl.push_back(mk("load_ff",    LD,   8'hFF, 8'h00, 1, 8'h00, 1, 0, 0, 8'h11));
    tbl.push_back(mk("pop_empty",  PO,   8'h00, 8'h00, 1, 8'h00, 0, 1, 0, 8'h11));
    tbl.push_back(mk("idle_noerr", IDLE, 8'h00, 8'h00, 1, 8'h00, 0, 0, 0, 8'h11));

    do_reset();
    memToReg = 1'b1;
    #1;
    chk_outs("reset", 0, 0, 0, 8'h00);

    foreach (tbl[i]) begin
      apply(tbl[i].op, tbl[i].a, tbl[i].d, tbl[i].mtr, tbl[i].alu);
      chk_outs(tbl[i].nm, tbl[i].ev, tbl[i].ee, tbl[i].esp, tbl[i].edo);
    end

    // Fill to full, overflow, drain, underflow.
    apply(ST, 8'hEF, 8'hA5, 0, 8'h00);
    for (int i = 0; i < DEPTH; i++) begin
      apply(PU, 8'h00, 8'(8'h40 + i), 0, 8'h00);
      chk($sformatf("fill_sp%0d", i), 32'(sp), 32'(i + 1));
    end
    chk("fill_full", 32'(full), 32'd1);
    apply(PU, 8'h00, 8'hFE, 0, 8'h00);
    chk_outs("push_full", 0, 1, DEPTH, 8'h00);
    apply(IDLE, 8'h00, 8'h00, 0, 8'h00);
    chk_outs("push_full_idle", 0, 0, DEPTH, 8'h00);
    apply(LD, 8'hEF, 8'h00, 1, 8'h00);
    chk_outs("ef_untouched", 1, 0, DEPTH, 8'hA5);
    for (int i = 0; i < DEPTH; i++) begin
      apply(PO, 8'h00, 8'h00, 1, 8'h00);
      chk_outs($sformatf("drain%0d", i), 1, 0, DEPTH - 1 - i, 8'(8'h40 + DEPTH - 1 - i));
    end
    apply(PO, 8'h00, 8'h00, 1, 8'h00);
    chk_outs("drain_underflow", 0, 1, 0, 8'h40);

    // Store and push together: nothing may change.
    apply(ST, 8'h40, 8'h12, 0, 8'h00);
    apply(ST | PU, 8'h40, 8'h99, 0, 8'h00);
    chk_outs("multi_op", 0, 1, 0, 8'h00);
    apply(LD, 8'h40, 8'h00, 1, 8'h00);
    chk_outs("multi_no_store", 1, 0, 0, 8'h12);
    apply(LD, 8'hFF, 8'h00, 1, 8'h00);
    chk_outs("multi_no_push", 1, 0, 0, 8'h40);

    // Reset arriving mid-cycle while a push is pending.
    apply(ST, 8'hFA, 8'h5E, 0, 8'h00);
    for (int i = 0; i < 5; i++) apply(PU, 8'h00, 8'(8'hC0 + i), 0, 8'h00);
    apply(LD, 8'hFB, 8'h00, 1, 8'h00);
    chk_outs("pre_reset_load", 1, 0, 5, 8'hC4);
    {wr_en, rd_en, push, pop} = PU;
    dat_in = 8'hEE;
    #3 reset = 1'b1;
    #1;
    chk_outs("async_reset", 0, 0, 0, 8'h00);
    @(posedge clk);
    #2;
    reset = 1'b0;
    {wr_en, rd_en, push, pop} = IDLE;
    apply(LD, 8'hFA, 8'h00, 1, 8'h00);
    chk_outs("reset_no_write", 1, 0, 0, 8'h5E);

    // Randomised run against a reference model.
    do_reset();
    msp = 0;
    mrd = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mmem[i] = 8'($urandom);
      apply(ST, 8'(i), mmem[i], 0, 8'h00);
    end
    for (int n = 0; n < 500; n++) begin
      logic [3:0] op;
      logic [7:0] a, d, alu;
      logic       mtr, ev, ee;
      int         r;
      r   = $urandom_range(0, 11);
      a   = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom);
      d   = 8'($urandom);
      alu = 8'($urandom);
      mtr = 1'($urandom);
      if (r < 2)       op = ST;
      else if (r < 4)  op = LD;
      else if (r < 7)  op = PU;
      else if (r < 9)  op = PO;
      else if (r < 11) op = IDLE;
      else begin
        op = 4'($urandom);
        while ($countones(op) < 2) op = 4'($urandom);
      end
      ev = 1'b0;
      ee = 1'b0;
      if ($countones(op) > 1) ee = 1'b1;
      else if (op == ST) mmem[a] = d;
      else if (op == LD) begin mrd = mmem[a]; ev = 1'b1; end
      else if (op == PU) begin
        if (msp == DEPTH) ee = 1'b1;
        else begin mmem[BASE - msp] = d; msp++; end
      end else if (op == PO) begin
        if (msp == 0) ee = 1'b1;
        else begin mrd = mmem[BASE - msp + 1]; msp--; ev = 1'b1; end
      end
      apply(op, a, d, mtr, alu);
      chk_outs($sformatf("rand%0d", n), ev, ee, msp, mtr ? mrd : alu);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dat_mem_stack.md
Name: dat_mem_stack

Overview:
- Parametrised successor to the 8-bit/256-word data memory.
- Provides a random-access load/store port plus a hardware stack (push/pop) carved from the top of the same array.
- Read data is registered: 1-cycle latency with a valid strobe.
- Keeps the memToReg writeback mux, so it drops into the datapath in the same slot as the current data memory.

Parameters:
- DW, 8, data word width in bits.
- AW, 8, address width; array depth is 2**AW words.
- STACK_DEPTH, 16, maximum stack entries; legal range 1 to 2**AW.
- STACK_BASE, 2**AW-1, address of the first (bottom) stack slot; the stack grows downward.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  store dat_in to core[addr].
- rd_en  in  1  load core[addr] into the read register.
- push  in  1  store dat_in at the stack top.
- pop  in  1  load the stack top into the read register and remove it.
- addr  in  AW  random-access address; ignored for push/pop.
- dat_in  in  DW  write data for store/push.
- ALU_out  in  DW  ALU result for the writeback mux.
- memToReg  in  1  1 selects the read register, 0 selects ALU_out.
- dat_out  out  DW  writeback value.
- rd_valid  out  1  high the cycle after an accepted rd_en or pop.
- sp  out  $clog2(STACK_DEPTH+1)  current stack entry count.
- full  out  1  sp == STACK_DEPTH.
- empty  out  1  sp == 0.
- err  out  1  one-cycle pulse: illegal or rejected request.

Behaviour:
- Reset (asynchronous, active-high): sp=0, rd_data=0, rd_valid=0, err=0. Array contents are not cleared.
  - After reset: dat_out = memToReg ? 0 : ALU_out, empty=1, full=0.
  - Reset asserted mid-operation aborts that cycle's op: no write, no sp change.
- Op legality: at most one of {wr_en, rd_en, push, pop} may be high per cycle.
  - Two or more high: no array write, sp unchanged, rd_data holds, rd_valid=0, err=1 next cycle.
- Store: core[addr] <= dat_in. rd_valid=0. Stores into the stack region are allowed, with no protection.
- Load: rd_data <= core[addr]; rd_valid=1 for exactly the next cycle. Latency is 1 cycle.
- Push, not full:
  - core[STACK_BASE - sp] <= dat_in; sp <= sp+1.
- Push when full: ignored (no write, sp held); err=1 next cycle.
- Pop, not empty:
  - rd_data <= core[STACK_BASE - sp + 1] (the current top); sp <= sp-1; rd_valid=1 next cycle.
- Pop when empty: ignored (rd_data held, rd_valid=0); err=1 next cycle.
- Idle (no op): rd_valid=0, err=0, rd_data holds its last value.
- dat_out is combinational: memToReg ? rd_data : ALU_out. It is valid for consumption only when rd_valid=1 if memToReg=1.
- full and empty are combinational decodes of sp.
- Address arithmetic is AW-bit. STACK_BASE - sp never wraps, given the parameter range check: instantiation fails elaboration if STACK_DEPTH > STACK_BASE+1.
- Back-to-back ops are fully pipelined:
  - push then pop next cycle returns the just-pushed value.
  - store then load of the same address next cycle returns the new data.
- rd_valid and err are registered single-cycle pulses. Neither persists across idle cycles.

Test Plan:
- Reset then idle, memToReg=1 -> dat_out=0x00, empty=1, sp=0. Set memToReg=0 with ALU_out=0x5A -> dat_out=0x5A.
- Store 0x3C @0x10, next cycle load @0x10 -> the cycle after: rd_valid=1, dat_out=0x3C (memToReg=1). The following cycle rd_valid=0 and dat_out still 0x3C.
- Push 0x11, 0x22, 0x33 on consecutive cycles, then pop x3:
  - sp goes 1,2,3 then back to 0.
  - Pops return 0x33, 0x22, 0x11 with rd_valid each cycle.
  - core[0xFF]=0x11 verified by a load from 0xFF.
- Fill to STACK_DEPTH=16 -> full=1. 17th push -> err=1 pulse, sp=16, core[0xEF] unchanged. Pop on empty after draining -> err=1, rd_valid=0.
- wr_en and push asserted together -> err=1, no array write (load from addr returns the old value), sp unchanged.
- Assert reset for a partial cycle during a push with sp=5 -> sp=0 immediately (asynchronous), rd_valid=0, and the pushed slot holds its old value.
